// File: rtl/alu_seq_arbiter.sv
// Round-robin arbiter sharing one bit-serial ALU between two requesters.
// Frames argument/command words onto sin and collects result/status words from sout.
module alu_seq_arbiter #(
  parameter int MAX_ARGS     = 10,
  parameter int RESULT_WORDS = 4,
  parameter int RESP_TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req0_valid,
  output logic                      req0_ready,
  input  logic [7:0]                req0_cmd,
  input  logic [3:0]                req0_argc,
  input  logic [8*MAX_ARGS-1:0]     req0_args,
  input  logic                      req0_bad_par,
  input  logic                      req1_valid,
  output logic                      req1_ready,
  input  logic [7:0]                req1_cmd,
  input  logic [3:0]                req1_argc,
  input  logic [8*MAX_ARGS-1:0]     req1_args,
  input  logic                      req1_bad_par,
  output logic                      sin,
  input  logic                      sout,
  output logic                      rsp_valid,
  output logic                      rsp_id,
  output logic [8*RESULT_WORDS-1:0] rsp_result,
  output logic [8:0]                rsp_status,
  output logic                      rsp_err,
  output logic                      rsp_timeout
);

  localparam int RW = 8 * RESULT_WORDS;
  localparam int AW = 8 * MAX_ARGS;
  localparam int TW = $clog2(RESP_TIMEOUT + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SEND = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_RECV = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [3:0]    ARGC_MAX = 4'(MAX_ARGS);
  localparam logic [3:0]    RX_FULL  = 4'(RESULT_WORDS);
  localparam logic [TW-1:0] TMO_LAST = TW'(RESP_TIMEOUT - 1);
  localparam logic [8:0]    ST_NOERR = 9'h100;

  logic [2:0]    state;
  logic          last_id;
  logic          cur_id;
  logic [7:0]    cmd_q;
  logic [3:0]    argc_q;
  logic [AW-1:0] args_q;
  logic          bad_par_q;
  logic [3:0]    bit_cnt;
  logic [3:0]    word_idx;
  logic [TW-1:0] timer;
  logic [9:0]    rx_word;
  logic [RW-1:0] result_q;
  logic [3:0]    rx_count;
  logic          err_q;

  logic          grant_any;
  logic          grant_id;
  logic [3:0]    tx_sel;
  logic [AW-1:0] tx_shift;
  logic [8:0]    tx_body;
  logic [9:0]    tx_word;
  logic          tx_bit;
  logic          rx_word_err;

  // Tie goes to the requester that was not served last.
  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = 1'b0;
    if (state == S_IDLE && !rst) begin
      if (req0_valid && req1_valid) begin
        grant_any = 1'b1;
        grant_id  = ~last_id;
      end else if (req0_valid) begin
        grant_any = 1'b1;
        grant_id  = 1'b0;
      end else if (req1_valid) begin
        grant_any = 1'b1;
        grant_id  = 1'b1;
      end
    end
  end

  assign req0_ready = grant_any && !grant_id;
  assign req1_ready = grant_any && grant_id;

  // Transmit word: arguments first, then the command; bad_par corrupts only word 0.
  always_comb begin
    tx_sel   = (word_idx < argc_q) ? word_idx : 4'd0;
    tx_shift = args_q >> {tx_sel, 3'b000};
    tx_body  = (word_idx < argc_q) ? {1'b0, tx_shift[7:0]} : {1'b1, cmd_q};
    tx_word  = {tx_body, (^tx_body) ^ (bad_par_q && word_idx == 4'd0)};
    tx_bit   = 1'b1;
    if (bit_cnt == 4'd0) begin
      tx_bit = 1'b0;
    end else if (bit_cnt <= 4'd10) begin
      tx_bit = tx_word[4'd10 - bit_cnt];
    end
  end

  // Driven from state so that an async reset returns the line to idle at once.
  assign sin = (state == S_SEND) ? tx_bit : 1'b1;

  assign rx_word_err = (^rx_word) | ~sout;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      last_id     <= 1'b1;
      cur_id      <= 1'b0;
      cmd_q       <= '0;
      argc_q      <= '0;
      args_q      <= '0;
      bad_par_q   <= 1'b0;
      bit_cnt     <= '0;
      word_idx    <= '0;
      timer       <= '0;
      rx_word     <= '0;
      result_q    <= '0;
      rx_count    <= '0;
      err_q       <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_result  <= '0;
      rsp_status  <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            cur_id    <= grant_id;
            cmd_q     <= grant_id ? req1_cmd : req0_cmd;
            args_q    <= grant_id ? req1_args : req0_args;
            bad_par_q <= grant_id ? req1_bad_par : req0_bad_par;
            if (grant_id) begin
              argc_q <= (req1_argc > ARGC_MAX) ? ARGC_MAX : req1_argc;
            end else begin
              argc_q <= (req0_argc > ARGC_MAX) ? ARGC_MAX : req0_argc;
            end
            bit_cnt  <= '0;
            word_idx <= '0;
            result_q <= '0;
            rx_count <= '0;
            err_q    <= 1'b0;
            state    <= S_SEND;
          end
        end

        S_SEND: begin
          if (bit_cnt == 4'd11) begin
            bit_cnt <= '0;
            if (word_idx == argc_q) begin
              timer <= TW'(1);
              state <= S_WAIT;
            end else begin
              word_idx <= word_idx + 4'd1;
            end
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end

        // timer holds cycles elapsed since the last stop bit.
        S_WAIT: begin
          if (!sout) begin
            bit_cnt <= '0;
            state   <= S_RECV;
          end else if (timer == TMO_LAST) begin
            rsp_valid   <= 1'b1;
            rsp_id      <= cur_id;
            rsp_result  <= '0;
            rsp_status  <= '0;
            rsp_err     <= err_q;
            rsp_timeout <= 1'b1;
            state       <= S_DONE;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        S_RECV: begin
          if (bit_cnt == 4'd10) begin
            bit_cnt <= '0;
            if (!rx_word[9]) begin
              result_q <= {result_q[RW-9:0], rx_word[8:1]};
              if (rx_count != 4'hF) begin
                rx_count <= rx_count + 4'd1;
              end
              err_q <= err_q | rx_word_err | (rx_count >= RX_FULL);
              timer <= TW'(1);
              state <= S_WAIT;
            end else begin
              rsp_valid   <= 1'b1;
              rsp_id      <= cur_id;
              rsp_result  <= result_q;
              rsp_status  <= rx_word[9:1];
              rsp_err     <= err_q | rx_word_err |
                             (rx_word[9:1] == ST_NOERR && rx_count < RX_FULL);
              rsp_timeout <= 1'b0;
              state       <= S_DONE;
            end
          end else begin
            rx_word <= {rx_word[8:0], sout};
            bit_cnt <= bit_cnt + 4'd1;
          end
        end

        S_DONE: begin
          last_id <= cur_id;
          state   <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
